// File: rtl/mm_cache.sv
// Direct-mapped write-back, write-allocate data cache: two Avalon-MM slave ports share one
// line store and refill/evict through a single-word Avalon-MM master towards SDRAM.
module mm_cache #(
    parameter int unsigned SIZE       = 8 * 1024,
    parameter int unsigned BLOCK_SIZE = 256
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] s0_address,
    input  logic [3:0]  s0_byteEnable,
    input  logic        s0_read,
    input  logic        s0_write,
    input  logic [31:0] s0_writeData,
    output logic [31:0] s0_readData,
    output logic        s0_waitRequest,
    output logic        s0_readDataValid,
    input  logic [31:0] s1_address,
    input  logic [3:0]  s1_byteEnable,
    input  logic        s1_read,
    input  logic        s1_write,
    input  logic [31:0] s1_writeData,
    output logic [31:0] s1_readData,
    output logic        s1_waitRequest,
    output logic        s1_readDataValid,
    output logic [31:0] m0_address,
    output logic [3:0]  m0_byteEnable,
    output logic        m0_read,
    output logic        m0_write,
    output logic [31:0] m0_writeData,
    input  logic [31:0] m0_readData,
    input  logic        m0_waitRequest,
    input  logic        m0_readDataValid,
    output logic        m0_beginBurstTransfer,
    output logic [7:0]  m0_burstCount
);
    localparam int unsigned LINES = SIZE / BLOCK_SIZE;
    localparam int unsigned WPL   = BLOCK_SIZE / 4;
    localparam int unsigned OFF_W = $clog2(WPL);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WB, ST_FILL} state_t;

    state_t             state;
    logic [31:0]        data_mem [LINES*WPL];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [IDX_W-1:0]   init_idx;
    logic [IDX_W-1:0]   lat_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic [OFF_W-1:0]   req_cnt;
    logic [OFF_W-1:0]   rsp_cnt;
    logic [OFF_W-1:0]   req_nxt;

    logic               s0_req, s1_req, hit0, hit1, sel1;
    logic               r_req, r_rd, r_wr, r_hit, is_idle, acc, miss;
    logic [IDX_W-1:0]   idx0, idx1, r_idx;
    logic [TAG_W-1:0]   tag0, tag1, r_tag;
    logic [OFF_W-1:0]   off0, off1, r_off;
    logic [3:0]         r_be;
    logic [31:0]        r_wd;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^{s0_address[1:0], s1_address[1:0]};

    // Address split, hit detection and fixed-priority arbitration (s0 wins)
    always_comb begin
        idx0    = s0_address[2+OFF_W +: IDX_W];
        idx1    = s1_address[2+OFF_W +: IDX_W];
        tag0    = s0_address[31 -: TAG_W];
        tag1    = s1_address[31 -: TAG_W];
        off0    = s0_address[2 +: OFF_W];
        off1    = s1_address[2 +: OFF_W];
        s0_req  = s0_read | s0_write;
        s1_req  = s1_read | s1_write;
        hit0    = valid_q[idx0] && (tag_mem[idx0] == tag0);
        hit1    = valid_q[idx1] && (tag_mem[idx1] == tag1);
        sel1    = !s0_req;
        r_req   = s0_req | s1_req;
        r_rd    = sel1 ? s1_read : s0_read;
        r_wr    = sel1 ? (s1_write & ~s1_read) : (s0_write & ~s0_read);
        r_hit   = sel1 ? hit1 : hit0;
        r_idx   = sel1 ? idx1 : idx0;
        r_tag   = sel1 ? tag1 : tag0;
        r_off   = sel1 ? off1 : off0;
        r_be    = sel1 ? s1_byteEnable : s0_byteEnable;
        r_wd    = sel1 ? s1_writeData : s0_writeData;
        is_idle = (state == ST_IDLE);
        acc     = is_idle && r_req && r_hit;
        miss    = is_idle && r_req && !r_hit;
        req_nxt = req_cnt + OFF_W'(1);
        s0_waitRequest = !is_idle || (s0_req && !hit0);
        s1_waitRequest = !is_idle || (s1_req && (s0_req || !hit1));
    end

    // Line storage: byte-merged write hits and refill words; not reset
    always_ff @(posedge clk) begin
        if (acc && r_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) data_mem[{r_idx, r_off}][8*b +: 8] <= r_wd[8*b +: 8];
            end
        end
        if (state == ST_FILL && m0_readDataValid) begin
            data_mem[{lat_idx, rsp_cnt}] <= m0_readData;
            if (rsp_cnt == OFF_W'(WPL - 1)) tag_mem[lat_idx] <= lat_tag;
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state                 <= ST_INIT;
            init_idx              <= '0;
            valid_q               <= '0;
            dirty_q               <= '0;
            lat_idx               <= '0;
            lat_tag               <= '0;
            req_cnt               <= '0;
            rsp_cnt               <= '0;
            s0_readData           <= '0;
            s0_readDataValid      <= 1'b0;
            s1_readData           <= '0;
            s1_readDataValid      <= 1'b0;
            m0_address            <= '0;
            m0_byteEnable         <= '0;
            m0_read               <= 1'b0;
            m0_write              <= 1'b0;
            m0_writeData          <= '0;
            m0_beginBurstTransfer <= 1'b0;
            m0_burstCount         <= '0;
        end else begin
            s0_readDataValid      <= 1'b0;
            s1_readDataValid      <= 1'b0;
            m0_beginBurstTransfer <= 1'b0;
            m0_byteEnable         <= 4'hF;
            m0_burstCount         <= 8'd1;
            case (state)
                ST_INIT: begin
                    valid_q[init_idx] <= 1'b0;
                    dirty_q[init_idx] <= 1'b0;
                    init_idx          <= init_idx + IDX_W'(1);
                    if (init_idx == IDX_W'(LINES - 1)) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (acc) begin
                        if (r_rd && sel1) begin
                            s1_readData      <= data_mem[{r_idx, r_off}];
                            s1_readDataValid <= 1'b1;
                        end else if (r_rd) begin
                            s0_readData      <= data_mem[{r_idx, r_off}];
                            s0_readDataValid <= 1'b1;
                        end else begin
                            dirty_q[r_idx] <= 1'b1;
                        end
                    end else if (miss) begin
                        lat_idx               <= r_idx;
                        lat_tag               <= r_tag;
                        req_cnt               <= '0;
                        rsp_cnt               <= '0;
                        m0_beginBurstTransfer <= 1'b1;
                        if (valid_q[r_idx] && dirty_q[r_idx]) begin
                            state        <= ST_WB;
                            m0_write     <= 1'b1;
                            m0_address   <= {tag_mem[r_idx], r_idx, OFF_W'(0), 2'b00};
                            m0_writeData <= data_mem[{r_idx, OFF_W'(0)}];
                        end else begin
                            state      <= ST_FILL;
                            m0_read    <= 1'b1;
                            m0_address <= {r_tag, r_idx, OFF_W'(0), 2'b00};
                        end
                    end
                end
                ST_WB: begin
                    // Evict ascending; the last accepted write hands straight over to the refill
                    if (m0_write && !m0_waitRequest) begin
                        m0_beginBurstTransfer <= 1'b1;
                        if (req_cnt == OFF_W'(WPL - 1)) begin
                            state      <= ST_FILL;
                            m0_write   <= 1'b0;
                            m0_read    <= 1'b1;
                            req_cnt    <= '0;
                            m0_address <= {lat_tag, lat_idx, OFF_W'(0), 2'b00};
                        end else begin
                            req_cnt                <= req_nxt;
                            m0_address[2 +: OFF_W] <= req_nxt;
                            m0_writeData           <= data_mem[{lat_idx, req_nxt}];
                        end
                    end
                end
                ST_FILL: begin
                    // Read issue and data return run independently so reads can pipeline
                    if (m0_read && !m0_waitRequest) begin
                        if (req_cnt == OFF_W'(WPL - 1)) begin
                            m0_read <= 1'b0;
                        end else begin
                            req_cnt                <= req_nxt;
                            m0_address[2 +: OFF_W] <= req_nxt;
                            m0_beginBurstTransfer  <= 1'b1;
                        end
                    end
                    if (m0_readDataValid) begin
                        rsp_cnt <= rsp_cnt + OFF_W'(1);
                        if (rsp_cnt == OFF_W'(WPL - 1)) begin
                            valid_q[lat_idx] <= 1'b1;
                            dirty_q[lat_idx] <= 1'b0;
                            state            <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_mm_cache.sv
// Randomized bench for mm_cache: flat shadow memory as the CPU-visible reference, plus an
// SDRAM slave model with random stalls and read latency that logs all m0 traffic.
module tb_mm_cache;
    localparam int unsigned WPL = 64;

    logic        clk, rest;
    logic [31:0] s0_address, s0_writeData, s0_readData;
    logic [3:0]  s0_byteEnable;
    logic        s0_read, s0_write, s0_waitRequest, s0_readDataValid;
    logic [31:0] s1_address, s1_writeData, s1_readData;
    logic [3:0]  s1_byteEnable;
    logic        s1_read, s1_write, s1_waitRequest, s1_readDataValid;
    logic [31:0] m0_address, m0_writeData, m0_readData;
    logic [3:0]  m0_byteEnable;
    logic        m0_read, m0_write, m0_waitRequest, m0_readDataValid;
    logic        m0_beginBurstTransfer;
    logic [7:0]  m0_burstCount;

    mm_cache dut (
        .clk(clk), .rest(rest),
        .s0_address(s0_address), .s0_byteEnable(s0_byteEnable), .s0_read(s0_read),
        .s0_write(s0_write), .s0_writeData(s0_writeData), .s0_readData(s0_readData),
        .s0_waitRequest(s0_waitRequest), .s0_readDataValid(s0_readDataValid),
        .s1_address(s1_address), .s1_byteEnable(s1_byteEnable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writeData(s1_writeData), .s1_readData(s1_readData),
        .s1_waitRequest(s1_waitRequest), .s1_readDataValid(s1_readDataValid),
        .m0_address(m0_address), .m0_byteEnable(m0_byteEnable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writeData(m0_writeData), .m0_readData(m0_readData),
        .m0_waitRequest(m0_waitRequest), .m0_readDataValid(m0_readDataValid),
        .m0_beginBurstTransfer(m0_beginBurstTransfer), .m0_burstCount(m0_burstCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          both_cnt = 0;
    logic [31:0] sdram  [int unsigned];
    logic [31:0] shadow [int unsigned];
    logic [31:0] rd_log[$], wr_log[$], wr_dat[$], pend_a[$];
    int          pend_t[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_get(input logic [31:0] a, input bit sh);
        int unsigned w = a >> 2;
        if (sh) return shadow.exists(w) ? shadow[w] : 32'h0;
        return sdram.exists(w) ? sdram[w] : 32'h0;
    endfunction

    // SDRAM slave: random stall, in-order read return with 1..3 cycle latency
    always @(negedge clk) begin
        cyc++;
        m0_waitRequest = ($urandom_range(0, 3) == 0);
        if (pend_a.size() != 0 && pend_t[0] <= cyc) begin
            m0_readDataValid = 1'b1;
            m0_readData      = mem_get(pend_a.pop_front(), 1'b0);
            void'(pend_t.pop_front());
        end else begin
            m0_readDataValid = 1'b0;
            m0_readData      = $urandom;
        end
    end

    always @(posedge clk) begin
        if (rest) begin
            if (m0_read && m0_write) both_cnt++;
            if (m0_read && !m0_waitRequest) begin
                rd_log.push_back(m0_address);
                pend_a.push_back(m0_address);
                pend_t.push_back(cyc + int'($urandom_range(1, 3)));
            end
            if (m0_write && !m0_waitRequest) begin
                wr_log.push_back(m0_address);
                wr_dat.push_back(m0_writeData);
                sdram[m0_address >> 2] = m0_writeData;
            end
        end
    end

    task automatic set_port(input int p, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        if (p == 0) begin
            s0_read = rd; s0_write = wr; s0_address = a; s0_writeData = wd; s0_byteEnable = be;
        end else begin
            s1_read = rd; s1_write = wr; s1_address = a; s1_writeData = wd; s1_byteEnable = be;
        end
    endtask

    // One CPU access; waits counts stalled cycles before the accepting edge
    task automatic xfer(input int p, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int waits);
        logic v;
        @(negedge clk);
        set_port(p, !wr, wr, a, wd, be);
        waits = 0;
        forever begin
            #1;
            if (!(p == 0 ? s0_waitRequest : s1_waitRequest)) break;
            @(negedge clk);
            waits++;
            if (waits > 4000) begin
                chk("req_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        @(negedge clk);
        rd = (p == 0) ? s0_readData : s1_readData;
        v  = (p == 0) ? s0_readDataValid : s1_readDataValid;
        chk(wr ? "wr_no_rdv" : "rd_rdv", 32'(v), wr ? 32'd0 : 32'd1);
        set_port(p, 1'b0, 1'b0, a, wd, be);
    endtask

    task automatic cpu_wr(input int p, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] d, old;
        int          w;
        xfer(p, 1'b1, a, wd, be, d, w);
        old = mem_get(a, 1'b1);
        for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
        shadow[a >> 2] = old;
    endtask

    task automatic cpu_rd(input int p, input logic [31:0] a, output logic [31:0] d, output int w);
        xfer(p, 1'b0, a, 32'h0, 4'h0, d, w);
        chk("rd_data", d, mem_get(a, 1'b1));
    endtask

    task automatic chk_log(input string tag, input logic [31:0] q[$], input logic [31:0] base);
        chk({tag, "_n"}, 32'(q.size()), 32'(WPL));
        if (q.size() == WPL)
            for (int i = 0; i < WPL; i++) chk(tag, q[i], base + 32'(i * 4));
    endtask

    task automatic clr_logs();
        rd_log.delete(); wr_log.delete(); wr_dat.delete();
    endtask

    logic [31:0] d, a;
    int          w, cnt;

    initial begin
        rest = 1'b0;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m0_waitRequest = 1'b0; m0_readDataValid = 1'b0; m0_readData = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_s0_wait", 32'(s0_waitRequest), 32'd1);
        chk("rst_s1_wait", 32'(s1_waitRequest), 32'd1);
        chk("rst_s0_rdv", 32'(s0_readDataValid), 32'd0);
        chk("rst_m0_cmd", {30'd0, m0_read, m0_write}, 32'd0);
        chk("rst_m0_be", 32'(m0_byteEnable), 32'd0);

        // INIT sweep: one line per cycle
        rest = 1'b1;
        #1;
        cnt = 0;
        while (s0_waitRequest && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("init_wait_cycles", 32'(cnt), 32'd32);

        clr_logs();
        cpu_rd(0, 32'h0, d, w);
        chk("t1_data", d, 32'h0);
        chk_log("t1_fill_addr", rd_log, 32'h0);
        chk("t1_no_wb", 32'(wr_log.size()), 32'd0);
        chk("m0_be", 32'(m0_byteEnable), 32'hF);
        chk("m0_burst", 32'(m0_burstCount), 32'd1);

        clr_logs();
        cpu_wr(0, 32'h10, 32'hAABBCCDD, 4'b0101);
        cpu_rd(0, 32'h10, d, w);
        chk("t2_data", d, 32'h00BB00DD);
        chk("t2_hit_waits", 32'(w), 32'd0);
        chk("t2_no_m0", 32'(rd_log.size() + wr_log.size()), 32'd0);

        clr_logs();
        cpu_rd(1, 32'h2010, d, w);
        chk("t3_data", d, 32'h0);
        chk_log("t3_wb_addr", wr_log, 32'h0);
        if (wr_dat.size() == WPL) chk("t3_wb_word4", wr_dat[4], 32'h00BB00DD);
        else chk("t3_wb_count", 32'(wr_dat.size()), 32'(WPL));
        chk_log("t3_fill_addr", rd_log, 32'h2000);

        clr_logs();
        cpu_rd(0, 32'h10, d, w);
        chk("t4_data", d, 32'h00BB00DD);
        chk_log("t4_fill_addr", rd_log, 32'h0);
        chk("t4_no_wb", 32'(wr_log.size()), 32'd0);

        // Simultaneous hits: s0 first, s1 the cycle after
        @(negedge clk);
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        set_port(1, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        #1;
        chk("t5_s0_wait", 32'(s0_waitRequest), 32'd0);
        chk("t5_s1_wait", 32'(s1_waitRequest), 32'd1);
        @(negedge clk);
        chk("t5_s0_rdv", 32'(s0_readDataValid), 32'd1);
        chk("t5_s0_data", s0_readData, 32'h00BB00DD);
        chk("t5_s1_rdv_early", 32'(s1_readDataValid), 32'd0);
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("t5_s1_wait2", 32'(s1_waitRequest), 32'd0);
        @(negedge clk);
        chk("t5_s1_rdv", 32'(s1_readDataValid), 32'd1);
        chk("t5_s1_data", s1_readData, mem_get(32'h14, 1'b1));
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Random mixed traffic: mostly a 16KB window (conflicting tags), some across 2MB
        for (int i = 0; i < 120; i++) begin
            a = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h001F_FFFC) : ($urandom & 32'h0000_3FFC);
            if ($urandom_range(0, 1) == 1) cpu_wr(int'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
            else cpu_rd(int'($urandom_range(0, 1)), a, d, w);
        end

        chk("m0_rd_wr_overlap", 32'(both_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
